// File: rtl/rf_pkg.sv
// Shared constants and types for the register file / write-back slice.
// Default geometry matches the original 8x16 stage.
package rf_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREGS = 8;
    localparam int DEF_AW    = $clog2(DEF_NREGS);

    localparam logic RST_BIT = 1'b0;

    typedef logic [DEF_AW-1:0] ridx_t;

endpackage

// File: rtl/dflipflop_en_rst.sv
// Enabled D flip-flop bank with asynchronous active-high reset.
module dflipflop_en_rst
    import rf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_o <= {WIDTH{RST_BIT}};
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back register file: source select, two bypassed read ports,
// optional zero register and a per-register busy scoreboard.
module regfile_writeback
    import rf_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NREGS   = DEF_NREGS,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      vsel,
    input  logic                      write,
    input  logic [$clog2(NREGS)-1:0]  writenum,
    input  logic [WIDTH-1:0]          C,
    input  logic [WIDTH-1:0]          datapath_in,
    output logic [WIDTH-1:0]          datapath_out,
    input  logic [$clog2(NREGS)-1:0]  readnum_a,
    input  logic [$clog2(NREGS)-1:0]  readnum_b,
    output logic [WIDTH-1:0]          data_a,
    output logic [WIDTH-1:0]          data_b,
    output logic                      busy_a,
    output logic                      busy_b,
    input  logic                      issue_valid,
    input  logic [$clog2(NREGS)-1:0]  issue_dest,
    output logic                      waw_hazard,
    output logic [NREGS*WIDTH-1:0]    regs_flat
);

    localparam int AW = $clog2(NREGS);

    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] wr_hit;
    logic [NREGS-1:0] iss_hit;

    assign data_in      = vsel ? datapath_in : C;
    assign datapath_out = C;

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        // Index 0 is hard-wired when ZERO_R0: never written, never busy.
        localparam bit IS_ZERO = ZERO_R0 && (i == 0);

        assign wr_hit[i]  = !IS_ZERO && write
                            && (writenum == AW'(i));
        assign iss_hit[i] = !IS_ZERO && issue_valid
                            && (issue_dest == AW'(i));

        dflipflop_en_rst #(.WIDTH(WIDTH)) u_data (
            .clk  (clk),
            .rst  (reset),
            .en_i (wr_hit[i]),
            .d_i  (data_in),
            .q_o  (regs_q[i])
        );

        // Issue outranks write-back: the new producer supersedes.
        dflipflop_en_rst #(.WIDTH(1)) u_busy (
            .clk  (clk),
            .rst  (reset),
            .en_i (wr_hit[i] | iss_hit[i]),
            .d_i  (iss_hit[i]),
            .q_o  (busy_q[i])
        );

        assign regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
    end

    always_comb begin
        data_a = regs_q[readnum_a];
        busy_a = busy_q[readnum_a];
        data_b = regs_q[readnum_b];
        busy_b = busy_q[readnum_b];
        if (BYPASS && wr_hit[readnum_a]) begin
            data_a = data_in;
            busy_a = iss_hit[readnum_a];
        end
        if (BYPASS && wr_hit[readnum_b]) begin
            data_b = data_in;
            busy_b = iss_hit[readnum_b];
        end
        if (reset) begin
            data_a = '0;
            data_b = '0;
            busy_a = 1'b0;
            busy_b = 1'b0;
        end
    end

    assign waw_hazard = !reset && issue_valid && busy_q[issue_dest];

endmodule
